// File: rtl/audio_pkg.sv
// Shared constants and types for the audio tone mixer / PWM output stage.
// Optional build macro used by the top level: AUDIO_SOFT_MUTE_EN.
package audio_pkg;

    localparam int PERWIDTH = 24;
    localparam int NCHAN    = 4;
    localparam int PWMBITS  = 5;
    localparam int CHAN_AMP = 3;
    localparam int PWM_MID  = 2 ** (PWMBITS - 1);

    // Extremes of the mixed level: every active channel pulling the same way.
    localparam int MIX_MIN  = PWM_MID - CHAN_AMP * NCHAN;
    localparam int MIX_MAX  = PWM_MID + CHAN_AMP * NCHAN;

    typedef logic [PERWIDTH-1:0] period_t;
    typedef logic [PWMBITS-1:0]  level_t;

endpackage

// File: rtl/audio_tone_mix_pwm_if.sv
// Tone-control inputs and PWM/amplifier outputs of the audio output stage.
interface audio_tone_mix_pwm_if;

    logic [audio_pkg::NCHAN-1:0]                    mute;
    logic [audio_pkg::NCHAN*audio_pkg::PERWIDTH-1:0] period;
    logic                                           audout;
    logic                                           aud_sd;
    audio_pkg::level_t                              level;

    modport master (output mute, period, input audout, aud_sd, level);
    modport slave  (input mute, period, output audout, aud_sd, level);

endinterface

// File: rtl/audio_square_osc.sv
// One square-wave tone channel: phase toggles every `period` cycles while active.
module audio_square_osc
    import audio_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    active,
    input  period_t period,
    output logic    phase
);

    period_t cnt_q, cnt_d;
    period_t period_q, period_d;
    logic    phase_q, phase_d;

    always_comb begin
        // NOTE: every signal gets its default first, so no path through this block infers a latch.
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        period_d = period;
        if (!active) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (period != period_q) begin
            // Restart the count on a new period so a shrinking period never overruns.
            cnt_d = '0;
        end else if (cnt_q == period - period_t'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + period_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            cnt_q    <= '0;
            period_q <= '0;
            phase_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            phase_q  <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/audio_tone_mix_pwm.sv
// Four-channel square-wave mixer driving a PWM DAC and the amplifier enable.
// Build macro AUDIO_SOFT_MUTE_EN: ramp the level one step per frame and hold the amp on until midscale.
module audio_tone_mix_pwm
    import audio_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    audio_tone_mix_pwm_if.slave  aud
);

    localparam level_t           PWM_MID_L = level_t'(PWM_MID);
    localparam level_t           PWM_LAST  = '1;
    localparam logic signed [7:0] MID_S    = 8'(PWM_MID);
    localparam logic signed [7:0] AMP_S    = 8'(CHAN_AMP);

    logic [NCHAN-1:0] chan_active;
    logic [NCHAN-1:0] phase;
    logic [NCHAN-1:0] act_q, act_d;

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        period_t chan_period;
        assign chan_period    = aud.period[i*PERWIDTH +: PERWIDTH];
        assign chan_active[i] = ~aud.mute[i] && (chan_period != '0);

        audio_square_osc u_osc (
            .clk    (clk),
            .reset  (reset),
            .active (chan_active[i]),
            .period (chan_period),
            .phase  (phase[i])
        );
    end

    // Mixer: each active channel adds +/-1, scaled by CHAN_AMP around midscale.
    logic signed [7:0] mix_sum;
    logic signed [7:0] target_wide;
    level_t            target;

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (act_q[i]) begin
                mix_sum = mix_sum + (phase[i] ? 8'sd1 : -8'sd1);
            end
        end
        target_wide = MID_S + AMP_S * mix_sum;
        target      = target_wide[PWMBITS-1:0];
    end

    level_t pwm_cnt_q, pwm_cnt_d;
    level_t level_q, level_d;
    logic   audout_q, audout_d;
    logic   aud_sd_q, aud_sd_d;

    always_comb begin
        act_d     = chan_active;
        pwm_cnt_d = pwm_cnt_q + level_t'(1);
        level_d   = level_q;
        // Level only moves on the last count of a frame, so a frame never sees two levels.
        if (pwm_cnt_q == PWM_LAST) begin
`ifdef AUDIO_SOFT_MUTE_EN
            if (target > level_q) begin
                level_d = level_q + level_t'(1);
            end else if (target < level_q) begin
                level_d = level_q - level_t'(1);
            end
`else
            level_d = target;
`endif
        end
        audout_d = (pwm_cnt_q < level_q);
`ifdef AUDIO_SOFT_MUTE_EN
        aud_sd_d = ~&aud.mute || (level_q != PWM_MID_L);
`else
        aud_sd_d = ~&aud.mute;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q     <= '0;
            pwm_cnt_q <= '0;
            level_q   <= PWM_MID_L;
            audout_q  <= 1'b0;
            aud_sd_q  <= 1'b0;
        end else begin
            act_q     <= act_d;
            pwm_cnt_q <= pwm_cnt_d;
            level_q   <= level_d;
            audout_q  <= audout_d;
            aud_sd_q  <= aud_sd_d;
        end
    end

    assign aud.audout = audout_q;
    assign aud.aud_sd = aud_sd_q;
    assign aud.level  = level_q;

    // Four channels at +/-CHAN_AMP can never push the mix outside the PWM range.
    a_target_range : assert property (@(posedge clk) disable iff (reset)
        (target_wide >= MIX_MIN) && (target_wide <= MIX_MAX));

endmodule

// File: tb/tb_audio_tone_mix_pwm.sv
// Scoreboard bench for audio_tone_mix_pwm: directed stimulus queues expected level / enable events,
// a negedge monitor pops and compares them whenever the DUT changes an output or leaves reset.
module tb_audio_tone_mix_pwm;
    import audio_pkg::*;

    typedef struct {
        string name;
        int    lvl;
        int    sd;         // expected aud_sd when leaving reset, -1 on ordinary level changes
    } lvl_item_t;

    typedef struct {
        string name;
        int    val;
        bit    from_level; // latency measured from last level change instead of last mute change
    } sd_item_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    audio_tone_mix_pwm_if aud_if ();

    audio_tone_mix_pwm dut (
        .clk   (clk),
        .reset (reset),
        .aud   (aud_if)
    );

    always #5 clk = ~clk;

    int        n_tests = 0;
    int        n_fail  = 0;
    lvl_item_t lvl_q[$];
    sd_item_t  sd_q[$];

    // Edges since reset release; after edge n (n = 0 is the first unreset edge) ncyc == n + 1.
    int ncyc = 0;
    always @(posedge clk) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string what, input int act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected output event, value %0d, nothing expected", what, act);
    endtask

    // ---------------- monitor ----------------
    int          cyc = 0;
    bit          in_rst = 1'b1;
    int          last_level = 0;
    int          last_sd = 0;
    logic [3:0]  last_mute = '0;
    int          lvl_cyc = 0;
    int          mute_cyc = 0;
    int          win = 0;
    int          ones = 0;
    int          win_exp = 0;
    string       win_name = "";

    always @(negedge clk) begin : mon
        lvl_item_t it;
        sd_item_t  si;
        int        cur;
        cyc++;
        if (reset) begin
            in_rst = 1'b1;
            win    = 0;
        end else begin
            // Duty over the 32 cycles that follow a level update.
            if (win > 0) begin
                ones += int'(aud_if.audout);
                win--;
                if (win == 0) check({win_name, "_duty"}, ones, win_exp);
            end
            if (aud_if.mute != last_mute) begin
                last_mute = aud_if.mute;
                mute_cyc  = cyc;
            end
            if (in_rst) begin
                in_rst     = 1'b0;
                last_level = int'(aud_if.level);
                last_sd    = int'(aud_if.aud_sd);
                last_mute  = aud_if.mute;
                lvl_cyc    = cyc;
                mute_cyc   = cyc;
                if (lvl_q.size() == 0) begin
                    unexpected("reset_release", last_level);
                end else begin
                    it = lvl_q.pop_front();
                    check({it.name, "_level"}, last_level, it.lvl);
                    check({it.name, "_sd"}, last_sd, it.sd);
                    win = 32; ones = 0; win_exp = it.lvl; win_name = it.name;
                end
            end else begin
                cur = int'(aud_if.level);
                if (cur != last_level) begin
                    if (lvl_q.size() == 0) begin
                        unexpected("level_change", cur);
                    end else begin
                        it = lvl_q.pop_front();
                        check({it.name, "_level"}, cur, it.lvl);
                        check({it.name, "_frame_align"}, (cyc - lvl_cyc) % 32, 0);
                        win = 32; ones = 0; win_exp = it.lvl; win_name = it.name;
                    end
                    last_level = cur;
                    lvl_cyc    = cyc;
                end
                cur = int'(aud_if.aud_sd);
                if (cur != last_sd) begin
                    if (sd_q.size() == 0) begin
                        unexpected("aud_sd_change", cur);
                    end else begin
                        si = sd_q.pop_front();
                        check({si.name, "_sd"}, cur, si.val);
                        check({si.name, "_sd_latency"}, cyc - (si.from_level ? lvl_cyc : mute_cyc), 1);
                    end
                    last_sd = cur;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic [3:0] m, input int p0, input int p1, input int p2, input int p3);
        aud_if.mute   = m;
        aud_if.period = {period_t'(p3), period_t'(p2), period_t'(p1), period_t'(p0)};
    endtask

    task automatic push_lvl(input string name, input int lvl);
        lvl_q.push_back('{name: name, lvl: lvl, sd: -1});
    endtask

    task automatic push_start(input string name);
        lvl_q.push_back('{name: name, lvl: PWM_MID, sd: 0});
    endtask

    task automatic push_sd(input string name, input int val, input bit from_level);
        sd_q.push_back('{name: name, val: val, from_level: from_level});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_edge(input int e);
        while (ncyc < e + 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int b;
        b = budget;
        while ((lvl_q.size() != 0 || sd_q.size() != 0) && b > 0) begin
            @(posedge clk);
            #1;
            b--;
        end
        if (lvl_q.size() != 0 || sd_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d level and %0d enable events still pending, expected 0",
                     name, lvl_q.size(), sd_q.size());
            lvl_q.delete();
            sd_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int p_edge;
        set_in(4'b1111, 0, 0, 0, 0);
        reset = 1'b1;
        step(4);

        // All muted after reset: midscale, 16/32 duty, amplifier off, no level change.
        push_start("reset");
        reset = 1'b0;
        step(200);
        wait_drain("reset", 50);

`ifndef AUDIO_SOFT_MUTE_EN
        // Channel 0 alone, half-period 40: level alternates 13 / 19.
        push_sd("ch0_on", 1, 1'b0);
        push_lvl("ch0_lo1", 13);
        push_lvl("ch0_hi1", 19);
        push_lvl("ch0_lo2", 13);
        push_lvl("ch0_hi2", 19);
        push_lvl("ch0_lo3", 13);
        set_in(4'b1110, 40, 0, 0, 0);
        wait_drain("ch0_tone", 500);

        push_sd("ch0_off", 0, 1'b0);
        push_lvl("all_muted", 16);
        set_in(4'b1111, 0, 0, 0, 0);
        wait_drain("all_muted", 100);

        // All four channels aligned at half-period 100: full swing 4 / 28, then jump back to 16.
        push_sd("all_on", 1, 1'b0);
        push_lvl("all_lo1", 4);
        push_lvl("all_hi1", 28);
        push_lvl("all_lo2", 4);
        push_lvl("all_hi2", 28);
        set_in(4'b0000, 100, 100, 100, 100);
        wait_drain("all_tone", 700);

        push_sd("all_off", 0, 1'b0);
        push_lvl("mute_jump", 16);
        set_in(4'b1111, 100, 100, 100, 100);
        wait_drain("mute_jump", 100);

        // Unmuted channel with a zero period stays silent.
        push_sd("ch0_zero_per", 1, 1'b0);
        set_in(4'b1110, 0, 100, 100, 100);
        step(100);
        wait_drain("zero_period", 50);

        // Period 1000 started on a frame boundary P; at counter 500 switch to 10.
        // First toggle lands on edge P+511, seen by the boundary at P+512.
        p_edge = ncyc + 1;
        while ((p_edge % 32) != 31) p_edge++;
        wait_edge(p_edge - 1);
        push_lvl("slow_tone", 13);
        set_in(4'b1110, 1000, 100, 100, 100);
        wait_edge(p_edge + 500);
        push_lvl("fast_hi1", 19);
        push_lvl("fast_lo1", 13);
        push_lvl("fast_hi2", 19);
        set_in(4'b1110, 10, 100, 100, 100);
        wait_drain("period_switch", 300);

        push_sd("fast_off", 0, 1'b0);
        push_lvl("fast_muted", 16);
        set_in(4'b1111, 10, 100, 100, 100);
        wait_drain("fast_muted", 100);

        push_sd("final_on", 1, 1'b0);
        push_lvl("final_tone", 4);
        set_in(4'b0000, 100, 100, 100, 100);
        wait_drain("final_tone", 100);
`else
        // Soft ramp: down to 4, up to 28 after the phases flip, then back to 16 once muted.
        push_sd("tones_on", 1, 1'b0);
        for (int l = 15; l >= 4; l--) push_lvl("ramp_down", l);
        for (int l = 5; l <= 28; l++) push_lvl("ramp_up", l);
        set_in(4'b0000, 1000, 1000, 1000, 1000);
        wait_drain("ramp_in", 3000);

        for (int l = 27; l >= 16; l--) push_lvl("ramp_mute", l);
        push_sd("amp_off", 0, 1'b1);
        set_in(4'b1111, 1000, 1000, 1000, 1000);
        wait_drain("ramp_mute", 600);

        push_sd("final_on", 1, 1'b0);
        push_lvl("final_tone", 15);
        set_in(4'b0000, 100, 100, 100, 100);
        wait_drain("final_tone", 100);
`endif

        // Reset in the middle of a frame: everything back to midscale with a full clean frame after.
        step(5);
        reset = 1'b1;
        set_in(4'b1111, 0, 0, 0, 0);
        step(3);
        push_start("mid_reset");
        reset = 1'b0;
        step(40);
        wait_drain("mid_reset", 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
